climate_zone_ctrl: RTL and testbench
====================================

Name: climate_zone_ctrl

Overview:
- Multi-zone heating/cooling controller for the smart-home top level.
- Generalises the single-zone AC, which heats at 18 or below and cools at 22 or above, to ZONES independent zones.
- Adds per-zone hysteresis, minimum dwell time, a global mode select, per-zone enable and sensor-fault detection.
- Outputs drive per-zone heater/cooler actuators and a status count.

Parameters:
- ZONES, 4: number of independent zones (1..8).
- TEMP_W, 5: temperature sample width, unsigned degrees C.
- HEAT_ON, 18: enter HEAT when temp <= HEAT_ON.
- HEAT_OFF, 20: leave HEAT when temp >= HEAT_OFF.
- COOL_ON, 22: enter COOL when temp >= COOL_ON.
- COOL_OFF, 20: leave COOL when temp <= COOL_OFF.
- MIN_DWELL, 8: minimum cycles in a state before a thermal transition (>=1).
- Legal only if HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON < 2**TEMP_W-1; elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- temperature  in  ZONES*TEMP_W  packed samples; zone i at bits [i*TEMP_W +: TEMP_W].
- zone_en  in  ZONES  per-zone enable.
- mode  in  2  0=OFF, 1=AUTO, 2=HEAT_ONLY, 3=COOL_ONLY.
- heating  out  ZONES  heater on, per zone.
- cooling  out  ZONES  cooler on, per zone.
- fault  out  ZONES  sensor fault flag, per zone.
- active_cnt  out  $clog2(ZONES+1)  number of zones with heating or cooling asserted.

Behaviour:
- Reset: all zones IDLE; heating, cooling, fault, active_cnt = 0. Dwell counters preset to MIN_DWELL so the first transition after reset is not delayed.
- Per-zone FSM with states IDLE, HEAT, COOL. All inputs sampled on rising clk; state and outputs are registered.
- Latency: an input change at edge N is reflected on outputs after edge N (visible in cycle N+1).
- heat_ok = mode is AUTO or HEAT_ONLY, and zone_en is set, and no fault.
- cool_ok = mode is AUTO or COOL_ONLY, and zone_en is set, and no fault.
- dwell_done = dwell counter == MIN_DWELL. The counter clears to 0 on every state change, increments each cycle and saturates at MIN_DWELL.
- IDLE -> HEAT: dwell_done and heat_ok and temp <= HEAT_ON.
- IDLE -> COOL: dwell_done and cool_ok and temp >= COOL_ON. The two conditions are mutually exclusive by the parameter rule.
- HEAT -> IDLE, thermal: dwell_done and temp >= HEAT_OFF.
- HEAT -> IDLE, forced: heat_ok deasserts. Dwell is ignored because safety overrides dwell.
- COOL -> IDLE: symmetric, using COOL_OFF and cool_ok.
- HEAT <-> COOL is never direct; the zone passes through IDLE and serves a full dwell there.
- Sensor fault: temp == all-ones. fault[i] sets on the next edge and the zone is forced to IDLE. fault clears on the first cycle temp is not all-ones; normal dwell rules then apply.
- Hysteresis band: inside the band the zone holds its state. Example: HEAT remains for temp 19 until 20 is reached.
- heating[i] = (state==HEAT); cooling[i] = (state==COOL); never both high.
- active_cnt is the registered popcount of (heating | cooling), updated on the same edge as the states.
- mode change mid-operation: forced exits apply the next edge; entries still require dwell_done.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- Zones are fully independent; there is no cross-zone arbitration.

Decomposition:
- Package climate_pkg: zone state enum (IDLE/HEAT/COOL), mode encoding constants (MODE_OFF/AUTO/HEAT_ONLY/COOL_ONLY), sensor-fault code function.
- Sub-module climate_zone_fsm: one zone's FSM, dwell counter and fault flag; parameters TEMP_W and the thresholds. Instantiated ZONES times in a generate loop.
- Top level: slices the packed temperature bus and computes the registered active_cnt popcount.

Test Plan:
- Reset then AUTO, zone_en=all ones, all temps 15: all heating=1 after the first edge; active_cnt=4; cooling=0.
- Zone0 in HEAT, temp steps 15 -> 19 -> 20 at cycle 3 after entry: heating[0] holds until dwell is met (8 cycles after entry), then clears one edge later at 20; at 19 it stays 1.
- Zone1 temp 25 in AUTO: cooling[1]=1. Temp drops to 10: cooling drops only after dwell and temp<=20. heating[1] rises only after 8 further IDLE cycles; never both high.
- Zone2 heating, mode set to COOL_ONLY at cycle 2 of HEAT: heating[2]=0 on the next edge despite dwell=2; stays IDLE while temp=15.
- Zone3 temp=31 (all ones) while cooling: fault[3]=1 and cooling[3]=0 next edge. Temp=25: fault clears, cooling resumes after 8 cycles.
- Assert rst asynchronously mid-cycle with zones active: all outputs 0 before the next clk edge. Release: the first transition occurs on the first edge, with no dwell delay.

Source files
------------

// File: rtl/climate_zone_ctrl_pkg.sv
// Shared types for the multi-zone climate controller: zone states, mode encoding and the
// sensor-fault code.
package climate_pkg;

   typedef enum logic [1:0] {
      ZoneIdle = 2'd0,
      ZoneHeat = 2'd1,
      ZoneCool = 2'd2
   } zone_state_e;

   typedef enum logic [1:0] {
      ModeOff      = 2'd0,
      ModeAuto     = 2'd1,
      ModeHeatOnly = 2'd2,
      ModeCoolOnly = 2'd3
   } mode_e;

   // A disconnected or shorted sensor reads as all-ones.
   function automatic logic [31:0] fault_code(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/climate_zone_ctrl_if.sv
// Sensor/actuator bundle between the climate controller and the rest of the smart-home top.
interface climate_zone_ctrl_if #(
   parameter int unsigned ZONES  = 4,
   parameter int unsigned TEMP_W = 5
);
   localparam int unsigned CntW = $clog2(ZONES + 1);

   logic [ZONES*TEMP_W-1:0] temperature;
   logic [ZONES-1:0]        zone_en;
   logic [1:0]              mode;
   logic [ZONES-1:0]        heating;
   logic [ZONES-1:0]        cooling;
   logic [ZONES-1:0]        fault;
   logic [CntW-1:0]         active_cnt;

   modport master (
      output temperature, zone_en, mode,
      input  heating, cooling, fault, active_cnt
   );

   modport slave (
      input  temperature, zone_en, mode,
      output heating, cooling, fault, active_cnt
   );
endinterface

// File: rtl/climate_zone_fsm.sv
// One zone: IDLE/HEAT/COOL state machine with hysteresis thresholds, minimum dwell counter
// and registered sensor-fault flag.
module climate_zone_fsm
   import climate_pkg::*;
#(
   parameter int unsigned TEMP_W    = 5,
   parameter int unsigned HEAT_ON   = 18,
   parameter int unsigned HEAT_OFF  = 20,
   parameter int unsigned COOL_ON   = 22,
   parameter int unsigned COOL_OFF  = 20,
   parameter int unsigned MIN_DWELL = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [TEMP_W-1:0] temp_i,
   input  logic              en_i,
   input  logic [1:0]        mode_i,
   output logic              heating_o,
   output logic              cooling_o,
   output logic              fault_o,
   output logic              active_d_o
);
   localparam int unsigned CntW = $clog2(MIN_DWELL + 1);

   zone_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            fault_q, fault_d;

   logic sensor_bad, heat_ok, cool_ok, dwell_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ZoneIdle;
         cnt_q   <= CntW'(MIN_DWELL);
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      sensor_bad = (temp_i == TEMP_W'(fault_code(TEMP_W)));
      heat_ok    = (mode_i == ModeAuto || mode_i == ModeHeatOnly) && en_i && !sensor_bad;
      cool_ok    = (mode_i == ModeAuto || mode_i == ModeCoolOnly) && en_i && !sensor_bad;
      dwell_done = (cnt_q == CntW'(MIN_DWELL));
      fault_d    = sensor_bad;
      state_d    = state_q;

      // Loss of permission exits immediately; thermal exits and all entries wait for dwell.
      unique case (state_q)
         ZoneIdle: begin
            if (dwell_done && heat_ok && temp_i <= TEMP_W'(HEAT_ON)) begin
               state_d = ZoneHeat;
            end else if (dwell_done && cool_ok && temp_i >= TEMP_W'(COOL_ON)) begin
               state_d = ZoneCool;
            end
         end
         ZoneHeat: begin
            if (!heat_ok || (dwell_done && temp_i >= TEMP_W'(HEAT_OFF))) state_d = ZoneIdle;
         end
         ZoneCool: begin
            if (!cool_ok || (dwell_done && temp_i <= TEMP_W'(COOL_OFF))) state_d = ZoneIdle;
         end
         default: state_d = ZoneIdle;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (dwell_done) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_comb begin
      heating_o  = (state_q == ZoneHeat);
      cooling_o  = (state_q == ZoneCool);
      fault_o    = fault_q;
      active_d_o = (state_d != ZoneIdle);
   end

endmodule

// File: rtl/climate_zone_ctrl.sv
// Multi-zone heating/cooling controller: one independent FSM per zone plus a registered count
// of zones currently heating or cooling.
module climate_zone_ctrl
   import climate_pkg::*;
#(
   parameter int unsigned ZONES     = 4,
   parameter int unsigned TEMP_W    = 5,
   parameter int unsigned HEAT_ON   = 18,
   parameter int unsigned HEAT_OFF  = 20,
   parameter int unsigned COOL_ON   = 22,
   parameter int unsigned COOL_OFF  = 20,
   parameter int unsigned MIN_DWELL = 8
) (
   input  logic                clk,
   input  logic                rst,
   climate_zone_ctrl_if.slave  bus_io
);
   localparam int unsigned CntW = $clog2(ZONES + 1);

   if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON &&
         COOL_ON < ((1 << TEMP_W) - 1) && MIN_DWELL >= 1 && ZONES >= 1 && ZONES <= 8))
   begin : gen_param_check
      $error("climate_zone_ctrl: illegal threshold/zone parameter set");
   end

   logic [ZONES-1:0] heat, cool, flt, active_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   for (genvar i = 0; i < ZONES; i++) begin : gen_zone
      climate_zone_fsm #(
         .TEMP_W   (TEMP_W),
         .HEAT_ON  (HEAT_ON),
         .HEAT_OFF (HEAT_OFF),
         .COOL_ON  (COOL_ON),
         .COOL_OFF (COOL_OFF),
         .MIN_DWELL(MIN_DWELL)
      ) u_zone (
         .clk_i     (clk),
         .rst_i     (rst),
         .temp_i    (bus_io.temperature[i*TEMP_W +: TEMP_W]),
         .en_i      (bus_io.zone_en[i]),
         .mode_i    (bus_io.mode),
         .heating_o (heat[i]),
         .cooling_o (cool[i]),
         .fault_o   (flt[i]),
         .active_d_o(active_d[i])
      );
   end

   // Count from next-state so the total lands on the same edge as the zone states.
   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 0; i < ZONES; i++) begin
         cnt_d = cnt_d + CntW'(active_d[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus_io.heating    = heat;
   assign bus_io.cooling    = cool;
   assign bus_io.fault      = flt;
   assign bus_io.active_cnt = cnt_q;

endmodule

// File: tb/tb_climate_zone_ctrl.sv
// Bench for climate_zone_ctrl: directed scenarios then randomized temperatures/modes, with a
// queue-based scoreboard fed by a behavioural per-zone thermostat model.
module tb_climate_zone_ctrl;
   localparam int unsigned ZONES     = 4;
   localparam int unsigned TEMP_W    = 5;
   localparam int unsigned HEAT_ON   = 18;
   localparam int unsigned HEAT_OFF  = 20;
   localparam int unsigned COOL_ON   = 22;
   localparam int unsigned COOL_OFF  = 20;
   localparam int unsigned MIN_DWELL = 8;
   localparam int unsigned BAD_TEMP  = 31;

   typedef struct {
      logic [ZONES-1:0] heat;
      logic [ZONES-1:0] cool;
      logic [ZONES-1:0] flt;
      int               cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   climate_zone_ctrl_if #(.ZONES(ZONES), .TEMP_W(TEMP_W)) bus ();

   climate_zone_ctrl #(
      .ZONES    (ZONES),
      .TEMP_W   (TEMP_W),
      .HEAT_ON  (HEAT_ON),
      .HEAT_OFF (HEAT_OFF),
      .COOL_ON  (COOL_ON),
      .COOL_OFF (COOL_OFF),
      .MIN_DWELL(MIN_DWELL)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t exp_q[$];

   // Reference model: who is heating/cooling, how many edges since the last change, fault.
   bit          m_heat [ZONES];
   bit          m_cool [ZONES];
   bit          m_fault[ZONES];
   int unsigned m_age  [ZONES];

   int unsigned      tmp[ZONES];
   logic [ZONES-1:0] en_v;
   logic [1:0]       mode_v;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   function automatic void model_reset();
      for (int z = 0; z < ZONES; z++) begin
         m_heat[z]  = 1'b0;
         m_cool[z]  = 1'b0;
         m_fault[z] = 1'b0;
         m_age[z]   = MIN_DWELL;
      end
   endfunction

   function automatic exp_t model_step();
      exp_t e;
      e.cnt = 0;
      for (int z = 0; z < ZONES; z++) begin
         int unsigned t = tmp[z];
         bit bad     = (t == BAD_TEMP);
         bit ok_h    = (mode_v == 2'd1 || mode_v == 2'd2) && en_v[z] && !bad;
         bit ok_c    = (mode_v == 2'd1 || mode_v == 2'd3) && en_v[z] && !bad;
         bit settled = (m_age[z] >= MIN_DWELL);
         bit nh      = m_heat[z];
         bit nc      = m_cool[z];
         if (m_heat[z]) begin
            if (!ok_h || (settled && t >= HEAT_OFF)) nh = 1'b0;
         end else if (m_cool[z]) begin
            if (!ok_c || (settled && t <= COOL_OFF)) nc = 1'b0;
         end else if (settled && ok_h && t <= HEAT_ON) begin
            nh = 1'b1;
         end else if (settled && ok_c && t >= COOL_ON) begin
            nc = 1'b1;
         end
         if (nh != m_heat[z] || nc != m_cool[z]) m_age[z] = 0;
         else if (m_age[z] < MIN_DWELL) m_age[z] = m_age[z] + 1;
         m_heat[z]  = nh;
         m_cool[z]  = nc;
         m_fault[z] = bad;
         e.heat[z]  = nh;
         e.cool[z]  = nc;
         e.flt[z]   = bad;
         e.cnt      = e.cnt + ((nh || nc) ? 1 : 0);
      end
      return e;
   endfunction

   task automatic step();
      logic [ZONES*TEMP_W-1:0] tv;
      @(negedge clk);
      rst = 1'b0;
      for (int z = 0; z < ZONES; z++) tv[z*TEMP_W +: TEMP_W] = TEMP_W'(tmp[z]);
      bus.temperature = tv;
      bus.zone_en     = en_v;
      bus.mode        = mode_v;
      exp_q.push_back(model_step());
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Reset lands mid-cycle, away from both clock edges.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_heating", int'(bus.heating), 0);
      chk("async_rst_cooling", int'(bus.cooling), 0);
      chk("async_rst_fault", int'(bus.fault), 0);
      chk("async_rst_cnt", int'(bus.active_cnt), 0);
      model_reset();
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("heating", int'(bus.heating), int'(e.heat));
            chk("cooling", int'(bus.cooling), int'(e.cool));
            chk("fault", int'(bus.fault), int'(e.flt));
            chk("active_cnt", int'(bus.active_cnt), e.cnt);
         end
      end
   end

   initial begin : stimulus
      int unsigned base[ZONES];
      int drain;
      bus.temperature = '0;
      bus.zone_en     = '0;
      bus.mode        = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_heating", int'(bus.heating), 0);
      chk("reset_cooling", int'(bus.cooling), 0);
      chk("reset_fault", int'(bus.fault), 0);
      chk("reset_cnt", int'(bus.active_cnt), 0);

      // All zones cold in AUTO: heat on the very first edge.
      mode_v = 2'd1;
      en_v   = '1;
      for (int z = 0; z < ZONES; z++) tmp[z] = 15;
      steps(3);
      // Zone0 inside the band, then at HEAT_OFF; zone1 hot then cold.
      tmp[0] = 19;
      tmp[1] = 25;
      steps(6);
      tmp[0] = 20;
      steps(12);
      tmp[1] = 10;
      steps(24);
      // Mode flip forces heating zones off immediately.
      for (int z = 0; z < ZONES; z++) tmp[z] = 15;
      steps(12);
      mode_v = 2'd3;
      steps(5);
      mode_v = 2'd1;
      // Zone3 cooling then a sensor fault.
      tmp[3] = 25;
      steps(20);
      tmp[3] = BAD_TEMP;
      steps(2);
      tmp[3] = 25;
      steps(12);
      // Reset with zones active; first edge after release transitions with no dwell.
      do_reset();
      for (int z = 0; z < ZONES; z++) tmp[z] = (z % 2 == 0) ? 12 : 26;
      steps(4);

      for (int z = 0; z < ZONES; z++) base[z] = tmp[z] == BAD_TEMP ? 20 : tmp[z];
      for (int c = 0; c < 3000; c++) begin
         for (int z = 0; z < ZONES; z++) begin
            int unsigned r = $urandom_range(0, 99);
            if (r < 30 && base[z] > 8) base[z] = base[z] - 1;
            else if (r >= 70 && base[z] < 28) base[z] = base[z] + 1;
            tmp[z] = ($urandom_range(0, 99) < 2) ? BAD_TEMP : base[z];
            if ($urandom_range(0, 199) == 0) en_v[z] = ~en_v[z];
         end
         if ($urandom_range(0, 99) == 0) mode_v = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 599) == 0) do_reset();
         step();
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
